// File: rtl/axi_master_wr_pipe.sv
// Purpose : pipelined AXI4 write master; AW and W decoupled, up to MAX_OUTSTANDING bursts in flight.
// Latency : accept N -> awvalid N+1; idle W engine -> wvalid N+2; B handshake M -> wr_done M+1.
// Backpr. : cmd_ready drops while AW is pending or MAX_OUTSTANDING bursts are unresponded.
// Ports   : cmd_* (user burst command), wr_data/wr_strb/wr_data_req (show-ahead beat source),
//           wr_done/wr_err/busy (completion status), m_axi_aw*/w*/b* (AXI4 write channels).
module axi_master_wr_pipe #(
    parameter int          ADDR_WIDTH      = 30,
    parameter int          DATA_WIDTH      = 64,
    parameter int          ID_WIDTH        = 4,
    parameter int unsigned AXI_ID          = 0,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    output logic                      wr_data_req,
    output logic                      wr_done,
    output logic                      wr_err,
    output logic                      busy,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {W_IDLE, W_BURST} w_state_e;

    logic                  awvalid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]            awlen_q;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic                  bready_q, wr_done_q, wr_err_q;

    logic [7:0]            fifo_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0]         fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [OW-1:0]         fifo_cnt_q;
    logic                  fifo_pop;

    w_state_e              w_state_q, w_state_d;
    logic                  wvalid_q, wvalid_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d, beat_len_q, beat_len_d;

    logic                  cmd_accept, w_hs, b_hs;
    logic                  unused_bid;

    // Response ordering is implied by command order, so BID carries no information here.
    assign unused_bid = ^m_axi_bid;

    assign cmd_ready   = !awvalid_q && (outstanding_q < OW'(MAX_OUTSTANDING));
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign w_hs        = wvalid_q && m_axi_wready;
    assign b_hs        = m_axi_bvalid && bready_q;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'($clog2(DATA_WIDTH/8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wvalid = wvalid_q;
    // Derived from registers only so a slave that waits for wlast before raising wready cannot deadlock.
    assign m_axi_wlast  = wvalid_q && (beat_cnt_q == beat_len_q);
    assign wr_data_req  = w_hs;

    assign m_axi_bready = bready_q;
    assign wr_done      = wr_done_q;
    assign wr_err       = wr_err_q;
    assign busy         = (outstanding_q != '0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        outstanding_d = outstanding_q;
        if (cmd_accept && !b_hs) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!cmd_accept && b_hs) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    // W engine: pops one length per burst; a pop on the last beat chains bursts without a bubble.
    always_comb begin
        w_state_d  = w_state_q;
        wvalid_d   = wvalid_q;
        beat_cnt_d = beat_cnt_q;
        beat_len_d = beat_len_q;
        fifo_pop   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (fifo_cnt_q != '0) begin
                    fifo_pop   = 1'b1;
                    beat_len_d = fifo_mem_q[fifo_rd_ptr_q];
                    beat_cnt_d = '0;
                    wvalid_d   = 1'b1;
                    w_state_d  = W_BURST;
                end
            end
            W_BURST: begin
                if (w_hs) begin
                    if (m_axi_wlast) begin
                        if (fifo_cnt_q != '0) begin
                            fifo_pop   = 1'b1;
                            beat_len_d = fifo_mem_q[fifo_rd_ptr_q];
                            beat_cnt_d = '0;
                        end else begin
                            wvalid_d  = 1'b0;
                            w_state_d = W_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            outstanding_q <= '0;
            bready_q      <= 1'b0;
            wr_done_q     <= 1'b0;
            wr_err_q      <= 1'b0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
            w_state_q     <= W_IDLE;
            wvalid_q      <= 1'b0;
            beat_cnt_q    <= '0;
            beat_len_q    <= '0;
        end else begin
            if (cmd_accept) begin
                awvalid_q <= 1'b1;
                awaddr_q  <= cmd_addr;
                awlen_q   <= cmd_len;
            end else if (m_axi_awready) begin
                awvalid_q <= 1'b0;
            end
            outstanding_q <= outstanding_d;
            // Looks at the next count so bready never lingers after the last response.
            bready_q      <= (outstanding_d != '0);
            wr_done_q     <= b_hs;
            wr_err_q      <= b_hs && (m_axi_bresp != 2'b00);
            // Entries never exceed outstanding, so the length FIFO cannot overflow.
            if (cmd_accept) begin
                fifo_wr_ptr_q <= ptr_inc(fifo_wr_ptr_q);
            end
            if (fifo_pop) begin
                fifo_rd_ptr_q <= ptr_inc(fifo_rd_ptr_q);
            end
            if (cmd_accept && !fifo_pop) begin
                fifo_cnt_q <= fifo_cnt_q + OW'(1);
            end else if (!cmd_accept && fifo_pop) begin
                fifo_cnt_q <= fifo_cnt_q - OW'(1);
            end
            w_state_q  <= w_state_d;
            wvalid_q   <= wvalid_d;
            beat_cnt_q <= beat_cnt_d;
            beat_len_q <= beat_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            fifo_mem_q[fifo_wr_ptr_q] <= cmd_len;
        end
    end

endmodule

// File: tb/tb_axi_master_wr_pipe.sv
// Purpose : directed self-checking bench for axi_master_wr_pipe (default parameters).
// Latency : inputs driven and outputs sampled 1 ns after each rising edge.
// Backpr. : every wait on the DUT is bounded by a cycle budget.
module tb_axi_master_wr_pipe;
    localparam int AW = 30;
    localparam int DW = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, cmd_valid, cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_strb;
    logic            wr_data_req, wr_done, wr_err, busy;
    logic [IW-1:0]   m_axi_awid, m_axi_bid;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize, m_axi_awprot;
    logic [1:0]      m_axi_awburst, m_axi_bresp;
    logic            m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [3:0]      m_axi_awcache, m_axi_awqos;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic            m_axi_bvalid, m_axi_bready;

    int checks = 0;
    int errors = 0;
    int src_idx = 0;

    function automatic logic [DW-1:0] data_of(input int i);
        return {32'hDA7A_0000 | 32'(i), ~32'(i)};
    endfunction
    function automatic logic [DW/8-1:0] strb_of(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Show-ahead source: the current beat is always visible and advances on wr_data_req.
    assign wr_data = data_of(src_idx);
    assign wr_strb = strb_of(src_idx);
    always @(posedge clk) if (wr_data_req) src_idx <= src_idx + 1;

    axi_master_wr_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_req(wr_data_req),
        .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [7:0] l);
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("issue_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic b_drain(input int n, input logic [1:0] resp, output int dn, output int en);
        int given = 0;
        logic hs;
        dn = 0; en = 0;
        for (int i = 0; i < n + 4; i++) begin
            m_axi_bvalid = (given < n); m_axi_bresp = resp;
            hs = m_axi_bvalid && m_axi_bready;
            tick();
            if (hs) given++;
            if (wr_done) dn++;
            if (wr_err) en++;
        end
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    endtask

    task automatic run_single(input logic [AW-1:0] a);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 8'd0;
        chk("s_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("s_awvalid", m_axi_awvalid, 1);
        chk("s_awaddr", m_axi_awaddr, 64'(a));
        chk("s_awlen", m_axi_awlen, 0);
        chk("s_wvalid_early", m_axi_wvalid, 0);
        tick();
        chk("s_awvalid_clr", m_axi_awvalid, 0);
        chk("s_wvalid", m_axi_wvalid, 1);
        chk("s_wlast", m_axi_wlast, 1);
        chk("s_data_req", wr_data_req, 1);
        chk("s_wdata", m_axi_wdata, data_of(src_idx));
        tick();
        chk("s_wvalid_end", m_axi_wvalid, 0);
        chk("s_busy", busy, 1);
        chk("s_bready", m_axi_bready, 1);
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        tick();
        m_axi_bvalid = 1'b0;
        chk("s_done", wr_done, 1);
        chk("s_err", wr_err, 0);
        chk("s_busy_clr", busy, 0);
        chk("s_bready_clr", m_axi_bready, 0);
        tick();
        chk("s_done_pulse", wr_done, 0);
    endtask

    initial begin
        int k, wl, base, dn, en, accepts, beats, first, last;
        logic acc_now;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = '0;
        tick(); tick();
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_wlast", m_axi_wlast, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_awlen", m_axi_awlen, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();

        // Single beat burst plus AW constants.
        chk("awsize", m_axi_awsize, 3);
        chk("awburst", m_axi_awburst, 1);
        chk("awcache", m_axi_awcache, 2);
        chk("awid", m_axi_awid, 0);
        run_single(30'h100);

        // len=7 with wready toggling.
        m_axi_awready = 1'b1; m_axi_wready = 1'b0;
        base = src_idx;
        issue(30'h200, 8'd7);
        chk("b2_awlen", m_axi_awlen, 7);
        tick();
        k = 0; wl = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            m_axi_wready = (c % 2 == 0);
            #1;
            chk("b2_wvalid", m_axi_wvalid, 1);
            chk("b2_wlast", m_axi_wlast, (k == 7));
            chk("b2_wdata", m_axi_wdata, data_of(src_idx));
            chk("b2_wstrb", m_axi_wstrb, strb_of(src_idx));
            chk("b2_data_req", wr_data_req, m_axi_wready);
            if (m_axi_wready && m_axi_wlast) wl++;
            tick();
            if (m_axi_wready) k++;
        end
        m_axi_wready = 1'b1;
        #1;
        chk("b2_wvalid_end", m_axi_wvalid, 0);
        chk("b2_wlast_cnt", wl, 1);
        chk("b2_req_cnt", src_idx - base, 8);
        b_drain(1, 2'b00, dn, en);
        chk("b2_done_cnt", dn, 1);
        chk("b2_err_cnt", en, 0);

        // Four len=3 commands back to back, no responses.
        accepts = 0; beats = 0; wl = 0; first = -1; last = -1;
        for (int i = 0; i < 40; i++) begin
            cmd_valid = (accepts < 4); cmd_addr = 30'h1000 + 30'(accepts * 32); cmd_len = 8'd3;
            acc_now = cmd_valid && cmd_ready;
            if (m_axi_wvalid) begin
                beats++;
                if (m_axi_wlast) wl++;
                if (first < 0) first = i;
                last = i;
            end
            tick();
            if (acc_now) begin
                accepts++;
                if (accepts == 4) begin
                    cmd_valid = 1'b0;
                    chk("full_ready_after_4th", cmd_ready, 0);
                end
            end
        end
        cmd_valid = 1'b0;
        chk("full_accepts", accepts, 4);
        chk("full_beats", beats, 16);
        chk("full_wlasts", wl, 4);
        chk("full_contig", last - first, 15);
        chk("full_ready_low", cmd_ready, 0);
        chk("full_busy", busy, 1);
        b_drain(4, 2'b00, dn, en);
        chk("full_done_cnt", dn, 4);
        chk("full_ready_back", cmd_ready, 1);
        chk("full_busy_clr", busy, 0);

        // Accept coinciding with a B handshake.
        for (int i = 0; i < 4; i++) issue(30'h2000 + 30'(i * 8), 8'd0);
        tick(); tick(); tick(); tick();
        chk("sc_full", cmd_ready, 0);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("sc_ready_3", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = 30'h2100; cmd_len = 8'd0; m_axi_bvalid = 1'b1;
        tick();
        cmd_valid = 1'b0; m_axi_bvalid = 1'b0;
        chk("sc_done", wr_done, 1);
        tick();
        chk("sc_unchanged", cmd_ready, 1);
        issue(30'h2200, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sc_stay_low", cmd_ready, 0);
        end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("sc_ready_after_b", cmd_ready, 1);
        b_drain(3, 2'b00, dn, en);
        chk("sc_drain_cnt", dn, 3);
        chk("sc_busy_clr", busy, 0);

        // Error response on the second of two bursts.
        issue(30'h3000, 8'd0);
        issue(30'h3008, 8'd0);
        tick(); tick(); tick();
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        tick();
        chk("e_done1", wr_done, 1);
        chk("e_err1", wr_err, 0);
        m_axi_bresp = 2'b10;
        tick();
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        chk("e_done2", wr_done, 1);
        chk("e_err2", wr_err, 1);
        tick();
        chk("e_done_clr", wr_done, 0);
        chk("e_err_clr", wr_err, 0);
        chk("e_busy_clr", busy, 0);

        // Reset during beat 3 of an 8-beat burst.
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        issue(30'h4000, 8'd7);
        tick(); tick(); tick(); tick();
        chk("r_mid_wvalid", m_axi_wvalid, 1);
        chk("r_mid_wlast", m_axi_wlast, 0);
        rst = 1'b1;
        tick();
        chk("r_wvalid", m_axi_wvalid, 0);
        chk("r_awvalid", m_axi_awvalid, 0);
        chk("r_bready", m_axi_bready, 0);
        chk("r_busy", busy, 0);
        chk("r_wlast", m_axi_wlast, 0);
        chk("r_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();
        chk("r_no_done", wr_done, 0);
        run_single(30'h5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
